// File: rtl/proc_mc.sv
// Multicycle 7-register processor core with a single request/acknowledge memory port.
// Registers R0..R6 live in the register file; the PC serves as R7.
module proc_mc #(
  parameter int unsigned DW    = 16,
  parameter int unsigned RSTPC = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_run,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_done,
  output logic          o_halted,
  output logic [DW-1:0] o_pc
);

  localparam int unsigned SW  = $clog2(DW);
  localparam int unsigned IRW = 10;
  localparam logic [DW-1:0] PC_RST = DW'(RSTPC);

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_MVNZ = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_MVI  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_AND  = 4'd11;
  localparam logic [3:0] OP_BEQZ = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  if ((DW < 16) || (DW > 32)) begin : g_dw_chk
    $error("proc_mc: DW must be in 16..32");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IMM    = 3'd3,
    S_MEM    = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_gpr [0:6];
  logic [DW-1:0]   r_pc;
  logic [IRW-1:0]  r_ir;
  logic [DW-1:0]   r_mdr;
  logic            r_z;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [DW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_done;
  logic            r_halted;

  logic [3:0]      w_op;
  logic [2:0]      w_x;
  logic [2:0]      w_y;
  logic [DW-1:0]   w_xv;
  logic [DW-1:0]   w_yv;
  logic [SW-1:0]   w_sh;
  logic [DW-1:0]   w_alu;
  logic            w_is_alu;
  logic            w_wb_en;
  logic [DW-1:0]   w_wb_data;
  logic [DW-1:0]   w_pc_next;

  // Only the opcode and the two register fields of the instruction word are kept.
  assign w_op = r_ir[9:6];
  assign w_x  = r_ir[5:3];
  assign w_y  = r_ir[2:0];
  assign w_xv = (w_x == 3'd7) ? r_pc : r_gpr[w_x];
  assign w_yv = (w_y == 3'd7) ? r_pc : r_gpr[w_y];
  assign w_sh = w_yv[SW-1:0];

  // ALU result for opcodes 5..11
  always_comb begin
    w_alu    = '0;
    w_is_alu = 1'b1;
    case (w_op)
      OP_ADD:  w_alu = w_xv + w_yv;
      OP_SUB:  w_alu = w_xv - w_yv;
      OP_OR:   w_alu = w_xv | w_yv;
      OP_SLT:  w_alu = DW'($signed(w_xv) < $signed(w_yv));
      OP_SLL:  w_alu = w_xv << w_sh;
      OP_SRL:  w_alu = w_xv >> w_sh;
      OP_AND:  w_alu = w_xv & w_yv;
      default: w_is_alu = 1'b0;
    endcase
  end

  // Register writeback selection and the PC value the next fetch will use
  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_data = w_alu;
    w_pc_next = r_pc;
    case (w_op)
      OP_MV: begin
        w_wb_en   = 1'b1;
        w_wb_data = w_yv;
      end
      OP_MVNZ: begin
        w_wb_en   = ~r_z;
        w_wb_data = w_yv;
      end
      OP_LD, OP_MVI: begin
        w_wb_en   = 1'b1;
        w_wb_data = r_mdr;
      end
      OP_BEQZ: begin
        if (w_xv == '0) w_pc_next = w_yv;
      end
      default: w_wb_en = w_is_alu;
    endcase
    if (w_wb_en && (w_x == 3'd7)) w_pc_next = w_wb_data;
  end

  // Control FSM, datapath registers and registered memory-port outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= PC_RST;
      r_ir        <= '0;
      r_mdr       <= '0;
      r_z         <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < 7; i++) r_gpr[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            r_ir      <= i_mem_rdata[DW-1 -: IRW];
            r_pc      <= r_pc + DW'(1);
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (w_op)
            OP_MVI: begin
              r_state    <= S_IMM;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_pc;
            end
            OP_LD: begin
              r_state    <= S_MEM;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_yv;
            end
            OP_ST: begin
              r_state     <= S_MEM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_yv;
              r_mem_wdata <= w_xv;
            end
            OP_HALT: begin
              r_state  <= S_HALT;
              r_done   <= 1'b1;
              r_halted <= 1'b1;
            end
            default: begin
              r_state <= S_EXEC;
              r_done  <= 1'b1;
            end
          endcase
        end
        S_IMM: begin
          if (i_mem_ack) begin
            r_mdr     <= i_mem_rdata;
            r_pc      <= r_pc + DW'(1);
            r_mem_req <= 1'b0;
            r_state   <= S_EXEC;
            r_done    <= 1'b1;
          end
        end
        S_MEM: begin
          if (i_mem_ack) begin
            r_mdr     <= i_mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= S_EXEC;
            r_done    <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_wb_en && (w_x != 3'd7)) r_gpr[w_x] <= w_wb_data;
          if (w_is_alu) r_z <= (w_alu == '0);
          r_pc <= w_pc_next;
          if (i_run) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_pc_next;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_done      = r_done;
  assign o_halted    = r_halted;
  assign o_pc        = r_pc;

endmodule

// File: tb/tb_proc_mc.sv
// Directed bench for proc_mc at DW=32: small programs run against a wait-state memory model,
// register contents observed through stores into that model.
module tb_proc_mc;

  localparam int unsigned DW = 32;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_MVNZ = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_MVI  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_AND  = 4'd11;
  localparam logic [3:0] OP_BEQZ = 4'd12;
  localparam logic [3:0] OP_NOP  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          w_req;
  logic          w_we;
  logic [DW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          w_done;
  logic          w_halted;
  logic [DW-1:0] w_pc;

  logic [31:0]   mem [0:255];
  logic          ld_we;
  logic [7:0]    ld_addr;
  logic [31:0]   ld_data;
  logic          spur;
  int unsigned   ack_dly;
  int unsigned   wcnt;
  int unsigned   wr_cnt;
  logic [31:0]   wr_addr [0:7];
  logic [31:0]   wr_data [0:7];

  logic [31:0]   prog [$];
  int            t_done [$];
  int            n_cmp;
  int            n_err;

  always #5 clk = ~clk;

  proc_mc #(.DW(DW), .RSTPC(0)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .o_mem_req   (w_req),
    .o_mem_we    (w_we),
    .o_mem_addr  (w_addr),
    .o_mem_wdata (w_wdata),
    .i_mem_ack   (ack),
    .i_mem_rdata (rdata),
    .o_done      (w_done),
    .o_halted    (w_halted),
    .o_pc        (w_pc)
  );

  // Memory model: ack after ack_dly wait cycles, optional spurious ack, write log
  assign ack   = (w_req && (wcnt >= ack_dly)) || spur;
  assign rdata = mem[w_addr[7:0]];

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (w_req && w_we && ack) mem[w_addr[7:0]] <= w_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= 0;
      wr_cnt <= 0;
    end else begin
      if (!w_req || ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (w_req && w_we && ack) begin
        wr_addr[3'(wr_cnt)] <= w_addr;
        wr_data[3'(wr_cnt)] <= w_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ignored low bits are filled with a nonzero pattern on purpose
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    return {op, x, y, 22'h155555};
  endfunction

  task automatic ins(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    prog.push_back(enc(op, x, y));
  endtask

  task automatic dat(input logic [31:0] v);
    prog.push_back(v);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = 8'(i);
      ld_data = prog[i];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    spur  = 1'b0;
    load_prog();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run until n retirements (bounded), then drop Run so the core parks in IDLE
  task automatic run_n(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    t_done.delete();
    run = 1'b1;
    while (seen < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (w_done) begin
        seen++;
        t_done.push_back(cyc);
      end
    end
    run = 1'b0;
    chk_eq("done_count", 64'(seen), 64'(n));
    @(negedge clk);
  endtask

  initial begin
    int req_cyc;
    int stable;
    int hit;
    int cnt;
    int cnt2;
    n_cmp   = 0;
    n_err   = 0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    ack_dly = 0;

    // Test 1: mvi/mvi/add, then dump R0 and R2 (mvnz with Z=0)
    prog.delete();
    ins(OP_MVI, 0, 0); dat(32'd5);
    ins(OP_MVI, 1, 0); dat(32'd3);
    ins(OP_ADD, 0, 1);
    ins(OP_MVNZ, 2, 1);
    ins(OP_MVI, 5, 0); dat(32'h40);
    ins(OP_ST, 0, 5);
    ins(OP_MVI, 6, 0); dat(32'h41);
    ins(OP_ST, 2, 6);
    rst_n = 1'b0;
    run   = 1'b0;
    spur  = 1'b0;
    load_prog();
    chk_eq("rst_ctl", {60'd0, w_req, w_we, w_done, w_halted}, 64'd0);
    chk_eq("rst_addr", 64'(w_addr), 64'd0);
    chk_eq("rst_wdata", 64'(w_wdata), 64'd0);
    chk_eq("rst_pc", 64'(w_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("idle_no_req", 64'(w_req), 64'd0);
    run_n(3);
    chk_eq("t1_lat_mvi", 64'(t_done[0]), 64'd4);
    chk_eq("t1_gap_mvi", 64'(t_done[1] - t_done[0]), 64'd4);
    chk_eq("t1_gap_add", 64'(t_done[2] - t_done[1]), 64'd3);
    chk_eq("t1_pc", 64'(w_pc), 64'd5);
    run_n(5);
    chk_eq("t1_r0", 64'(mem[8'h40]), 64'd8);
    chk_eq("t1_r2_mvnz", 64'(mem[8'h41]), 64'd3);
    chk_eq("t1_pc_end", 64'(w_pc), 64'd12);

    // Test 2: fetch with a 4-cycle ack delay
    prog.delete();
    ins(OP_MV, 1, 0);
    do_reset();
    ack_dly = 4;
    run     = 1'b1;
    req_cyc = 0;
    stable  = 1;
    hit     = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clk);
      if (w_req) begin
        req_cyc++;
        if (w_addr != '0 || w_we) stable = 0;
        if (ack) hit = 1;
      end
    end
    run = 1'b0;
    @(negedge clk);
    chk_eq("t2_req_cycles", 64'(req_cyc), 64'd5);
    chk_eq("t2_stable", 64'(stable), 64'd1);
    chk_eq("t2_req_drop", 64'(w_req), 64'd0);
    chk_eq("t2_pc_once", 64'(w_pc), 64'd1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (w_done) cnt++;
    end
    chk_eq("t2_one_done", 64'(cnt), 64'd1);
    chk_eq("t2_pc_final", 64'(w_pc), 64'd1);

    // Test 3: sub to zero sets Z, mvnz must not move
    prog.delete();
    ins(OP_MVI, 3, 0); dat(32'd7);
    ins(OP_MVI, 2, 0); dat(32'd1);
    ins(OP_SUB, 2, 2);
    ins(OP_MVNZ, 3, 2);
    ins(OP_MVI, 5, 0); dat(32'h50);
    ins(OP_ST, 3, 5);
    ins(OP_MVI, 6, 0); dat(32'h51);
    ins(OP_ST, 2, 6);
    ack_dly = 0;
    do_reset();
    run_n(8);
    chk_eq("t3_r3_kept", 64'(mem[8'h50]), 64'd7);
    chk_eq("t3_r2_zero", 64'(mem[8'h51]), 64'd0);
    chk_eq("t3_pc", 64'(w_pc), 64'd12);

    // Test 4: store then load through the memory model, 2 wait states
    prog.delete();
    ins(OP_MVI, 4, 0); dat(32'hABCD);
    ins(OP_MVI, 5, 0); dat(32'h20);
    ins(OP_ST, 4, 5);
    ins(OP_LD, 6, 5);
    ins(OP_MVI, 1, 0); dat(32'h60);
    ins(OP_ST, 6, 1);
    ack_dly = 2;
    do_reset();
    run_n(6);
    chk_eq("t4_wr_cnt", 64'(wr_cnt), 64'd2);
    chk_eq("t4_st_addr", 64'(wr_addr[0]), 64'h20);
    chk_eq("t4_st_data", 64'(wr_data[0]), 64'hABCD);
    chk_eq("t4_ld_val", 64'(mem[8'h60]), 64'hABCD);
    chk_eq("t4_pc", 64'(w_pc), 64'd9);

    // Test 5: add wraps to zero, Z=1 blocks mvnz, sll by 33 shifts by 1
    prog.delete();
    ins(OP_MVI, 0, 0); dat(32'hFFFF_FFFF);
    ins(OP_MVI, 1, 0); dat(32'd1);
    ins(OP_ADD, 0, 1);
    ins(OP_MVNZ, 2, 1);
    ins(OP_MVI, 3, 0); dat(32'd33);
    ins(OP_SLL, 1, 3);
    ins(OP_MVI, 5, 0); dat(32'h70);
    ins(OP_ST, 0, 5);
    ins(OP_MVI, 5, 0); dat(32'h71);
    ins(OP_ST, 2, 5);
    ins(OP_MVI, 5, 0); dat(32'h72);
    ins(OP_ST, 1, 5);
    ack_dly = 0;
    do_reset();
    run_n(12);
    chk_eq("t5_add_wrap", 64'(mem[8'h70]), 64'd0);
    chk_eq("t5_z_mvnz", 64'(mem[8'h71]), 64'd0);
    chk_eq("t5_sll33", 64'(mem[8'h72]), 64'd2);
    chk_eq("t5_pc", 64'(w_pc), 64'd18);

    // Test 6: slt signed, srl logical, or/and, taken beqz, mvi into R7
    prog.delete();
    ins(OP_MVI, 0, 0); dat(32'hFFFF_FFFE);
    ins(OP_MVI, 1, 0); dat(32'd3);
    ins(OP_SLT, 0, 1);
    ins(OP_MVI, 2, 0); dat(32'h8000_0000);
    ins(OP_SRL, 2, 1);
    ins(OP_MVI, 3, 0); dat(32'hF0);
    ins(OP_OR, 3, 1);
    ins(OP_MVI, 4, 0); dat(32'h3C);
    ins(OP_AND, 3, 4);
    ins(OP_MVI, 5, 0); dat(32'd20);
    ins(OP_BEQZ, 6, 5);
    ins(OP_MVI, 0, 0); dat(32'hDEAD);
    ins(OP_NOP, 0, 0);
    ins(OP_MVI, 5, 0); dat(32'h90);
    ins(OP_ST, 0, 5);
    ins(OP_MVI, 5, 0); dat(32'h91);
    ins(OP_ST, 2, 5);
    ins(OP_MVI, 5, 0); dat(32'h92);
    ins(OP_ST, 3, 5);
    ins(OP_MVI, 7, 0); dat(32'd40);
    do_reset();
    run_n(18);
    chk_eq("t6_slt", 64'(mem[8'h90]), 64'd1);
    chk_eq("t6_srl", 64'(mem[8'h91]), 64'h1000_0000);
    chk_eq("t6_or_and", 64'(mem[8'h92]), 64'h30);
    chk_eq("t6_wr_cnt", 64'(wr_cnt), 64'd3);
    chk_eq("t6_pc_r7", 64'(w_pc), 64'd40);

    // Test 7: reset during an IMM wait, spurious ack in IDLE, then HALT
    prog.delete();
    ins(OP_MVI, 0, 0); dat(32'd5);
    ins(OP_HALT, 0, 0);
    ack_dly = 3;
    do_reset();
    run = 1'b1;
    hit = 0;
    for (int c = 0; c < 40 && hit == 0; c++) begin
      @(negedge clk);
      if (w_req && w_addr == 32'd1) hit = 1;
    end
    chk_eq("t7_imm_seen", 64'(hit), 64'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    chk_eq("t7_rst_ctl", {60'd0, w_req, w_we, w_done, w_halted}, 64'd0);
    chk_eq("t7_rst_addr", 64'(w_addr), 64'd0);
    chk_eq("t7_rst_wdata", 64'(w_wdata), 64'd0);
    chk_eq("t7_rst_pc", 64'(w_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spur  = 1'b1;
    cnt   = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_req || w_pc != '0) cnt++;
    end
    spur = 1'b0;
    chk_eq("t7_spur_ignored", 64'(cnt), 64'd0);
    ack_dly = 0;
    run_n(2);
    chk_eq("t7_halt_lat", 64'(t_done[1] - t_done[0]), 64'd3);
    chk_eq("t7_halted", 64'(w_halted), 64'd1);
    chk_eq("t7_pc", 64'(w_pc), 64'd3);
    cnt  = 0;
    cnt2 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      run = ~run;
      if (w_req) cnt++;
      if (w_done) cnt2++;
    end
    run = 1'b0;
    chk_eq("t7_no_req", 64'(cnt), 64'd0);
    chk_eq("t7_no_done", 64'(cnt2), 64'd0);
    chk_eq("t7_still_halted", 64'(w_halted), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
